// File: rtl/rv32_pkg.sv
// ---------------------------------------------------------------------------
// rv32_pkg
// Shared definitions for the AtomRV32 decode and execute stages.
//   - opcode constants (shared with the ALU execute stage)
//   - immediate-format enumeration
//   - decoded-instruction record held in the decode stage's main/skid entries
// No ports; imported with `import rv32_pkg::*;`.
// ---------------------------------------------------------------------------
package rv32_pkg;

    localparam int XLEN  = 32;
    localparam int OPC_W = 7;

    localparam logic [OPC_W-1:0] BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_e;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  rs1;
        logic [XLEN-1:0]  rs2;
        logic [XLEN-1:0]  imm;
        logic [OPC_W-1:0] opcode;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        logic [4:0]       rd;
        logic             illegal;
    } decoded_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// ---------------------------------------------------------------------------
// imm_gen
// Purely combinational immediate generator. Chooses the immediate format
// from the opcode, builds the sign-extended immediate and flags opcodes the
// core does not implement.
// Ports:
//   instr   in  32  instruction word
//   imm     out 32  sign-extended immediate (0 for OP and for illegal words)
//   illegal out 1   opcode unsupported or instr[1:0] != 2'b11
// ---------------------------------------------------------------------------
module imm_gen
    import rv32_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    imm_fmt_e fmt;
    logic     known_opcode;

    always_comb begin
        fmt          = IMM_NONE;
        known_opcode = 1'b1;
        case (instr[OPC_W-1:0])
            OP_IMM, LOAD, JALR: fmt = IMM_I;
            STORE:              fmt = IMM_S;
            BRANCH:             fmt = IMM_B;
            LUI, AUIPC:         fmt = IMM_U;
            JAL:                fmt = IMM_J;
            OP:                 fmt = IMM_NONE;
            default:            known_opcode = 1'b0;
        endcase
    end

    // The low two bits are already part of every opcode constant, but the
    // compressed-encoding check is kept explicit so it survives opcode edits.
    assign illegal = !known_opcode || (instr[1:0] != 2'b11);

    always_comb begin
        imm = '0;
        if (!illegal) begin
            case (fmt)
                IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
                IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7],
                              instr[30:25], instr[11:8], 1'b0};
                IMM_U: imm = {instr[31:12], 12'b0};
                IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12],
                              instr[20], instr[30:21], 1'b0};
                default: imm = '0;
            endcase
        end
    end

endmodule

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
// AtomRV32 instruction decode pipeline stage. Decodes the offered instruction
// at accept time and hands the result to execute through a two-entry skid
// buffer (main entry drives the outputs, skid entry absorbs one extra word),
// so INSTR_READY is a flop and execute back-pressure never reaches fetch
// combinationally.
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   INSTR_VALID/INSTR_READY  fetch-side handshake (INSTR_READY registered)
//   INSTR_IN, PC_IN          instruction word and its PC
//   RS1_ADDR, RS2_ADDR       register-file read addresses (combinational)
//   RS1_DATA, RS2_DATA       register-file read data, captured on accept
//   FLUSH                    drop every held and offered instruction
//   EX_VALID/EX_READY        execute-side handshake
//   PC_OUT, RS1_OUT, RS2_OUT, IMM_OUT, OPCODE, FUNCT3, FUNCT7, RD_ADDR,
//   ILLEGAL                  decoded instruction for the ALU stage
// ---------------------------------------------------------------------------
module decode_stage
    import rv32_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int OPCODE_WIDTH = 7
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    INSTR_VALID,
    output logic                    INSTR_READY,
    input  logic [DATA_WIDTH-1:0]   INSTR_IN,
    input  logic [DATA_WIDTH-1:0]   PC_IN,
    output logic [4:0]              RS1_ADDR,
    output logic [4:0]              RS2_ADDR,
    input  logic [DATA_WIDTH-1:0]   RS1_DATA,
    input  logic [DATA_WIDTH-1:0]   RS2_DATA,
    input  logic                    FLUSH,
    output logic                    EX_VALID,
    input  logic                    EX_READY,
    output logic [DATA_WIDTH-1:0]   PC_OUT,
    output logic [DATA_WIDTH-1:0]   RS1_OUT,
    output logic [DATA_WIDTH-1:0]   RS2_OUT,
    output logic [DATA_WIDTH-1:0]   IMM_OUT,
    output logic [OPCODE_WIDTH-1:0] OPCODE,
    output logic [2:0]              FUNCT3,
    output logic [6:0]              FUNCT7,
    output logic [4:0]              RD_ADDR,
    output logic                    ILLEGAL
);

    decoded_t main_reg, main_next;
    decoded_t skid_reg, skid_next;
    logic     main_valid_reg, main_valid_next;
    logic     skid_valid_reg, skid_valid_next;
    logic     ready_reg;

    decoded_t        in_dec;
    logic [XLEN-1:0] gen_imm;
    logic            gen_illegal;
    logic            accept;
    logic            deliver;

    assign RS1_ADDR = INSTR_IN[19:15];
    assign RS2_ADDR = INSTR_IN[24:20];

    imm_gen u_imm_gen (
        .instr   (INSTR_IN),
        .imm     (gen_imm),
        .illegal (gen_illegal)
    );

    always_comb begin
        in_dec         = '0;
        in_dec.pc      = PC_IN;
        in_dec.rs1     = RS1_DATA;
        in_dec.rs2     = RS2_DATA;
        in_dec.imm     = gen_imm;
        in_dec.opcode  = INSTR_IN[OPC_W-1:0];
        in_dec.funct3  = INSTR_IN[14:12];
        in_dec.funct7  = INSTR_IN[31:25];
        in_dec.rd      = INSTR_IN[11:7];
        in_dec.illegal = gen_illegal;
    end

    assign accept  = INSTR_VALID && ready_reg;
    assign deliver = main_valid_reg && EX_READY;

    // ready_reg is only high while the skid entry is empty, so the FULL
    // branch never has to consider a simultaneous accept.
    always_comb begin
        main_next       = main_reg;
        skid_next       = skid_reg;
        main_valid_next = main_valid_reg;
        skid_valid_next = skid_valid_reg;
        if (FLUSH) begin
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else if (!main_valid_reg) begin
            if (accept) begin
                main_next       = in_dec;
                main_valid_next = 1'b1;
            end
        end else if (!skid_valid_reg) begin
            if (accept && deliver) begin
                main_next = in_dec;
            end else if (accept) begin
                skid_next       = in_dec;
                skid_valid_next = 1'b1;
            end else if (deliver) begin
                main_valid_next = 1'b0;
            end
        end else if (deliver) begin
            main_next       = skid_reg;
            skid_valid_next = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            main_reg       <= '0;
            skid_reg       <= '0;
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            ready_reg      <= 1'b0;
        end else begin
            main_reg       <= main_next;
            skid_reg       <= skid_next;
            main_valid_reg <= main_valid_next;
            skid_valid_reg <= skid_valid_next;
            ready_reg      <= !skid_valid_next;
        end
    end

    assign INSTR_READY = ready_reg;
    assign EX_VALID    = main_valid_reg;
    assign PC_OUT      = main_reg.pc;
    assign RS1_OUT     = main_reg.rs1;
    assign RS2_OUT     = main_reg.rs2;
    assign IMM_OUT     = main_reg.imm;
    assign OPCODE      = main_reg.opcode;
    assign FUNCT3      = main_reg.funct3;
    assign FUNCT7      = main_reg.funct7;
    assign RD_ADDR     = main_reg.rd;
    assign ILLEGAL     = main_reg.illegal;

endmodule
